// File: rtl/kernel_seq_ctrl.sv
// kernel_seq_ctrl: dtype-stream sequencer for the kernel row buffers.
// In: clk, resetb, dvi, dtypei, enable_req.
// Out: col_addr, rowbuf_we, wr_sel, valid_row, valid_col, kern_dv,
// enable_active, overflow_err, protocol_err.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h4
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h8
`endif

module kernel_seq_ctrl #(
  parameter int KERNEL_SIZE    = 3,
  parameter int MAX_COLS       = 1288,
  parameter int NUM_COLS_WIDTH = 11,
  parameter int SEL_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      dvi,
  input  logic [`DTYPE_WIDTH-1:0]   dtypei,
  input  logic                      enable_req,
  output logic [NUM_COLS_WIDTH-1:0] col_addr,
  output logic                      rowbuf_we,
  output logic [SEL_WIDTH-1:0]      wr_sel,
  output logic                      valid_row,
  output logic                      valid_col,
  output logic                      kern_dv,
  output logic                      enable_active,
  output logic                      overflow_err,
  output logic                      protocol_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_ROW   = 2'd2;

  localparam int RSW = $clog2(KERNEL_SIZE) + 1;
  localparam logic [RSW-1:0] ROWS_MAX =
    RSW'(KERNEL_SIZE - 1);
  localparam logic [NUM_COLS_WIDTH-1:0] COL_MAX =
    NUM_COLS_WIDTH'(MAX_COLS);
  localparam logic [NUM_COLS_WIDTH-1:0] COL_BORDER =
    NUM_COLS_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST =
    SEL_WIDTH'(KERNEL_SIZE - 2);

  logic [1:0]     state;
  logic [RSW-1:0] rows_seen;
  logic           is_fs;
  logic           is_fe;
  logic           is_rs;
  logic           is_re;
  logic           is_pix;
  logic           in_row;
  logic           col_ok;

  assign is_pix = |(dtypei & `DTYPE_PIXEL_MASK);
  assign is_fs  = dtypei == `DTYPE_FRAME_START;
  assign is_fe  = dtypei == `DTYPE_FRAME_END;
  assign is_rs  = dtypei == `DTYPE_ROW_START;
  assign is_re  = dtypei == `DTYPE_ROW_END;
  assign in_row = state == S_ROW;
  assign col_ok = col_addr < COL_MAX;

  assign valid_row = rows_seen >= ROWS_MAX;
  assign valid_col = col_addr >= COL_BORDER;

  // Write lands at col_addr in the buffer picked by wr_sel;
  // the same address reads the older rows for the window.
  assign rowbuf_we = dvi & enable_active & in_row
                   & is_pix & col_ok;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state         <= S_IDLE;
      col_addr      <= '0;
      wr_sel        <= '0;
      rows_seen     <= '0;
      kern_dv       <= 1'b0;
      enable_active <= 1'b0;
      overflow_err  <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      kern_dv <= 1'b0;
      if (dvi) begin
        unique case (1'b1)
          is_fs: begin
            state         <= S_FRAME;
            rows_seen     <= '0;
            wr_sel        <= '0;
            enable_active <= enable_req;
            overflow_err  <= 1'b0;
            protocol_err  <= 1'b0;
            kern_dv       <= 1'b1;
            // Pass-through frames keep the address parked at 0.
            if (!enable_req) col_addr <= '0;
          end
          is_rs: begin
            state    <= S_ROW;
            col_addr <= '0;
            if (state == S_FRAME) begin
              kern_dv <= valid_row | ~enable_active;
            end else begin
              protocol_err <= 1'b1;
              kern_dv      <= ~enable_active;
            end
          end
          is_pix: begin
            if (!in_row) begin
              protocol_err <= 1'b1;
              kern_dv      <= ~enable_active;
            end else if (!enable_active) begin
              kern_dv <= 1'b1;
            end else if (col_ok) begin
              col_addr <= col_addr + 1'b1;
              kern_dv  <= valid_row & valid_col;
            end else begin
              overflow_err <= 1'b1;
            end
          end
          is_re: begin
            if (in_row) begin
              state   <= S_FRAME;
              kern_dv <= valid_row | ~enable_active;
              if (enable_active) begin
                if (!valid_row) rows_seen <= rows_seen + 1'b1;
                // Oldest buffer advances: pointer rotation.
                wr_sel <= (wr_sel == SEL_LAST) ? '0
                        : wr_sel + 1'b1;
              end
            end else begin
              protocol_err <= 1'b1;
              kern_dv      <= ~enable_active;
            end
          end
          is_fe: begin
            state   <= S_IDLE;
            kern_dv <= 1'b1;
          end
          default: kern_dv <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// tb_kernel_seq_ctrl: directed + random bench for kernel_seq_ctrl
// against a token-level reference model.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h4
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h8
`endif

module tb_kernel_seq_ctrl;
  localparam int K = 3;
  localparam int MAXC = 1288;
  localparam logic [3:0] FS = `DTYPE_FRAME_START;
  localparam logic [3:0] FE = `DTYPE_FRAME_END;
  localparam logic [3:0] RS = `DTYPE_ROW_START;
  localparam logic [3:0] RE = `DTYPE_ROW_END;
  localparam logic [3:0] PX = 4'h9;
  localparam logic [3:0] HD = 4'h5;

  logic clk = 0;
  logic resetb = 0;
  logic dvi = 0;
  logic [3:0] dtypei = 4'h0;
  logic enable_req = 0;
  logic [10:0] col_addr;
  logic rowbuf_we;
  logic [1:0] wr_sel;
  logic valid_row, valid_col, kern_dv;
  logic enable_active, overflow_err, protocol_err;

  int n_checks = 0;
  int n_fail = 0;

  kernel_seq_ctrl dut (
    .clk(clk), .resetb(resetb), .dvi(dvi), .dtypei(dtypei),
    .enable_req(enable_req), .col_addr(col_addr),
    .rowbuf_we(rowbuf_we), .wr_sel(wr_sel),
    .valid_row(valid_row), .valid_col(valid_col),
    .kern_dv(kern_dv), .enable_active(enable_active),
    .overflow_err(overflow_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Reference model: frame position as plain counters.
  int  m_where;   // 0 idle, 1 between rows, 2 in row
  int  m_col, m_rows, m_sel;
  bit  m_en, m_ovf, m_perr, m_kdv;
  bit  exp_we, obs_we;

  function automatic logic [18:0] expv();
    return {11'(m_col), 2'(m_sel), m_rows >= K - 1,
            m_col >= K - 1, m_kdv, m_en, m_ovf, m_perr};
  endfunction

  function automatic logic [18:0] obsv();
    return {col_addr, wr_sel, valid_row, valid_col, kern_dv,
            enable_active, overflow_err, protocol_err};
  endfunction

  task automatic model_reset();
    m_where = 0; m_col = 0; m_rows = 0; m_sel = 0;
    m_en = 0; m_ovf = 0; m_perr = 0; m_kdv = 0;
  endtask

  task automatic model_apply(input bit dv, input logic [3:0] dt,
                             input bit er);
    bit pix;
    bit vr;
    pix = (dt & `DTYPE_PIXEL_MASK) != 0;
    vr = m_rows >= K - 1;
    exp_we = dv && m_en && m_where == 2 && pix && m_col < MAXC;
    m_kdv = 0;
    if (!dv) return;
    if (dt == FS) begin
      m_where = 1; m_rows = 0; m_sel = 0; m_en = er;
      m_ovf = 0; m_perr = 0; m_kdv = 1;
      if (!er) m_col = 0;
    end else if (pix) begin
      if (m_where != 2) begin
        m_perr = 1; m_kdv = !m_en;
      end else if (!m_en) begin
        m_kdv = 1;
      end else if (m_col < MAXC) begin
        m_kdv = vr && m_col >= K - 1;
        m_col++;
      end else begin
        m_ovf = 1;
      end
    end else if (dt == RS) begin
      if (m_where == 1) m_kdv = vr || !m_en;
      else begin m_perr = 1; m_kdv = !m_en; end
      m_where = 2; m_col = 0;
    end else if (dt == RE) begin
      if (m_where == 2) begin
        m_where = 1; m_kdv = vr || !m_en;
        if (m_en) begin
          if (m_rows < K - 1) m_rows++;
          m_sel = (m_sel + 1) % (K - 1);
        end
      end else begin
        m_perr = 1; m_kdv = !m_en;
      end
    end else if (dt == FE) begin
      m_where = 0; m_kdv = 1;
    end else begin
      m_kdv = 1;
    end
  endtask

  task automatic step(input bit dv, input logic [3:0] dt,
                      input bit er);
    @(negedge clk);
    dvi = dv; dtypei = dt; enable_req = er;
    #1;
    obs_we = rowbuf_we;
    model_apply(dv, dt, er);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetb = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (obsv() !== 19'd0 || rowbuf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%h we=%b want=0",
               obsv(), rowbuf_we);
    end
    @(negedge clk);
    resetb = 1;
  endtask

  task automatic test_kernel();
    int strobes;
    int want_str [4] = '{0, 0, 4, 4};
    int want_sel [4] = '{0, 1, 0, 1};
    step(1, FS, 1);
    for (int r = 0; r < 4; r++) begin
      step(1, RS, 1);
      strobes = 0;
      for (int c = 0; c < 6; c++) begin
        step(1, PX, 1);
        strobes += kern_dv;
        n_checks++;
        if (obsv() !== expv() || obs_we !== exp_we) begin
          n_fail++;
          $display("FAIL kernel_px r%0d c%0d got=%h/%b want=%h/%b",
                   r, c, obsv(), obs_we, expv(), exp_we);
        end
      end
      n_checks++;
      if (strobes != want_str[r]) begin
        n_fail++;
        $display("FAIL kernel_strobes row%0d got=%0d want=%0d",
                 r, strobes, want_str[r]);
      end
      n_checks++;
      if (wr_sel !== 2'(want_sel[r])) begin
        n_fail++;
        $display("FAIL wr_sel_at_row_end row%0d got=%0d want=%0d",
                 r, wr_sel, want_sel[r]);
      end
      step(1, RE, 1);
    end
    step(1, FE, 1);
    n_checks++;
    if (obsv() !== expv()) begin
      n_fail++;
      $display("FAIL kernel_end got=%h want=%h", obsv(), expv());
    end
  endtask

  task automatic test_overflow();
    int writes = 0;
    step(1, FS, 1);
    step(1, RS, 1);
    for (int i = 1; i <= MAXC + 3; i++) begin
      step(1, PX, 1);
      writes += obs_we;
      if (i == MAXC) begin
        n_checks++;
        if (col_addr !== 11'd1288 || overflow_err !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_last_fit col=%0d ovf=%b want 1288/0",
                   col_addr, overflow_err);
        end
      end
      if (i == MAXC + 1) begin
        n_checks++;
        if (overflow_err !== 1'b1 || obs_we !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_first ovf=%b we=%b want 1/0",
                   overflow_err, obs_we);
        end
      end
    end
    n_checks++;
    if (writes != MAXC || col_addr !== 11'd1288) begin
      n_fail++;
      $display("FAIL ovf_writes got=%0d col=%0d want=%0d/1288",
               writes, col_addr, MAXC);
    end
    step(1, RE, 1);
    step(1, FS, 1);
    n_checks++;
    if (overflow_err !== 1'b0 || obsv() !== expv()) begin
      n_fail++;
      $display("FAIL ovf_clear got=%h want=%h", obsv(), expv());
    end
  endtask

  task automatic test_enable_toggle();
    bit dv;
    logic [3:0] dt;
    step(1, FS, 1);
    step(1, RS, 1);
    repeat (3) step(1, PX, 1);
    repeat (3) step(1, PX, 0);
    n_checks++;
    if (enable_active !== 1'b1 || col_addr !== 11'd6) begin
      n_fail++;
      $display("FAIL en_midframe en=%b col=%0d want 1/6",
               enable_active, col_addr);
    end
    step(1, RE, 0);
    step(1, FE, 0);
    step(1, FS, 0);
    n_checks++;
    if (enable_active !== 1'b0 || col_addr !== 11'd0) begin
      n_fail++;
      $display("FAIL en_next_frame en=%b col=%0d want 0/0",
               enable_active, col_addr);
    end
    for (int i = 0; i < 60; i++) begin
      dv = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 5))
        0: dt = RS;
        1: dt = RE;
        2: dt = HD;
        default: dt = PX;
      endcase
      step(dv, dt, 0);
      n_checks++;
      if (obs_we !== 1'b0 || kern_dv !== dv
          || col_addr !== 11'd0 || valid_row !== 1'b0) begin
        n_fail++;
        $display("FAIL passthru i%0d we=%b kdv=%b col=%0d want 0/%b/0",
                 i, obs_we, kern_dv, col_addr, dv);
      end
    end
  endtask

  task automatic test_protocol();
    step(1, FS, 1);
    step(1, PX, 1);
    n_checks++;
    if (protocol_err !== 1'b1 || obs_we !== 1'b0
        || obsv() !== expv()) begin
      n_fail++;
      $display("FAIL proto_pixel got=%h we=%b want=%h/0",
               obsv(), obs_we, expv());
    end
    step(1, FS, 1);
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_clear got=%b want=0", protocol_err);
    end
    step(1, RE, 1);
    n_checks++;
    if (protocol_err !== 1'b1 || wr_sel !== 2'd0
        || valid_row !== 1'b0 || obsv() !== expv()) begin
      n_fail++;
      $display("FAIL proto_row_end got=%h want=%h",
               obsv(), expv());
    end
  endtask

  task automatic test_gap();
    int writes = 0;
    step(1, FS, 1);
    step(1, RS, 1);
    repeat (3) begin step(1, PX, 1); writes += obs_we; end
    for (int i = 0; i < 5; i++) begin
      step(0, PX, 1);
      writes += obs_we;
      n_checks++;
      if (kern_dv !== 1'b0 || col_addr !== 11'd3
          || obs_we !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_hold i%0d kdv=%b col=%0d we=%b",
                 i, kern_dv, col_addr, obs_we);
      end
    end
    repeat (3) begin step(1, PX, 1); writes += obs_we; end
    n_checks++;
    if (writes != 6 || col_addr !== 11'd6) begin
      n_fail++;
      $display("FAIL gap_writes got=%0d col=%0d want 6/6",
               writes, col_addr);
    end
    step(1, RE, 1);
  endtask

  task automatic test_async_reset();
    step(1, FS, 1);
    step(1, RS, 1);
    step(1, RE, 1);
    step(1, RS, 1);
    repeat (100) step(1, PX, 1);
    n_checks++;
    if (col_addr !== 11'd100 || wr_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL pre_reset col=%0d sel=%0d want 100/1",
               col_addr, wr_sel);
    end
    #2;
    resetb = 0;
    #1;
    model_reset();
    n_checks++;
    if (obsv() !== 19'd0 || rowbuf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%h we=%b want=0",
               obsv(), rowbuf_we);
    end
    @(negedge clk);
    resetb = 1;
    test_kernel();
  endtask

  task automatic test_random();
    bit dv;
    bit er = 1;
    logic [3:0] dt;
    int r;
    for (int i = 0; i < 3000; i++) begin
      dv = $urandom_range(0, 9) != 0;
      r = $urandom_range(0, 99);
      if (r < 55) dt = 4'(8 + $urandom_range(0, 7));
      else if (r < 67) dt = RS;
      else if (r < 79) dt = RE;
      else if (r < 82) dt = FS;
      else if (r < 85) dt = FE;
      else dt = 4'(5 + $urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) er = ~er;
      step(dv, dt, er);
      n_checks++;
      if (obsv() !== expv() || obs_we !== exp_we) begin
        n_fail++;
        $display("FAIL random i%0d dt=%h got=%h/%b want=%h/%b",
                 i, dt, obsv(), obs_we, expv(), exp_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_kernel();
    test_overflow();
    test_enable_toggle();
    test_protocol();
    test_gap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_seq_ctrl.md
Name: kernel_seq_ctrl

Overview:
- Sequencer for the kernel/row-buffer datapath. It parses the dtype stream and generates the shared column address, row-buffer write enable and a rotating row-buffer select. This lets the KERNEL_SIZE-1 line buffers be used by pointer rotation instead of data shifting.
- It also produces row/column validity and the kernel data-valid strobe.
- It applies enable changes only at frame boundaries, and flags line-length and protocol errors.
- It sits between the imager stream input and the kernel window/row-buffer RAMs.

Parameters:
- KERNEL_SIZE, 3: kernel edge length. Border = KERNEL_SIZE-1 rows/cols dropped.
- MAX_COLS, 1288: row-buffer depth in pixels.
- NUM_COLS_WIDTH, 11: width of the column address.
- SEL_WIDTH, 2: width of the buffer-select pointer. Must satisfy 2^SEL_WIDTH >= KERNEL_SIZE-1.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- dvi  in  1  input data valid
- dtypei  in  `DTYPE_WIDTH  input data type
- enable_req  in  1  requested kernel enable; sampled only at frame start
- col_addr  out  NUM_COLS_WIDTH  row-buffer address (registered)
- rowbuf_we  out  1  row-buffer write enable (combinational)
- wr_sel  out  SEL_WIDTH  index of the oldest buffer, which is read and then overwritten this row
- valid_row  out  1  rows_seen >= KERNEL_SIZE-1
- valid_col  out  1  col_addr >= KERNEL_SIZE-1
- kern_dv  out  1  registered output-valid strobe for the kernel stage
- enable_active  out  1  enable latched for the current frame
- overflow_err  out  1  sticky: row longer than MAX_COLS
- protocol_err  out  1  sticky: dtype out of sequence

Behaviour:
- Reset: resetb is asynchronous, active-low; clock is clk. On reset:
  - State = IDLE.
  - col_addr, wr_sel, rows_seen, kern_dv, enable_active, overflow_err and protocol_err are all 0.
- States:
  - IDLE: waiting for a frame.
  - FRAME: between rows.
  - ROW: inside a row.
- All transitions occur only on cycles with dvi=1. When dvi=0, state and counters hold and kern_dv <= 0.
- DTYPE_FRAME_START (any state):
  - Next state FRAME.
  - rows_seen <= 0; wr_sel <= 0.
  - enable_active <= enable_req.
  - Both error flags clear.
  - kern_dv <= 1.
- DTYPE_ROW_START:
  - From FRAME: next state ROW, col_addr <= 0, kern_dv <= valid_row.
  - From IDLE or ROW: set protocol_err; next state ROW; col_addr <= 0.
- Pixel (dtypei & `DTYPE_PIXEL_MASK nonzero):
  - In ROW with col_addr < MAX_COLS:
    - rowbuf_we = 1 in the same cycle.
    - col_addr <= col_addr + 1.
    - kern_dv <= valid_row & valid_col, evaluated on pre-increment values.
  - In ROW with col_addr == MAX_COLS: rowbuf_we = 0, col_addr holds, overflow_err set, kern_dv <= 0.
  - Outside ROW: rowbuf_we = 0, protocol_err set, kern_dv <= 0.
- DTYPE_ROW_END in ROW:
  - Next state FRAME.
  - kern_dv <= valid_row.
  - rows_seen increments, saturating at KERNEL_SIZE-1.
  - wr_sel <= (wr_sel == KERNEL_SIZE-2) ? 0 : wr_sel + 1.
- DTYPE_ROW_END outside ROW: protocol_err set; no counter change.
- DTYPE_FRAME_END: next state IDLE; kern_dv <= 1.
- Header and other dtypes: no state change; kern_dv <= 1.
- enable_active = 0 (pass-through mode):
  - Every dvi cycle gives kern_dv <= 1.
  - rowbuf_we = 0; col_addr and rows_seen are held at 0.
  - Error detection still runs.
- enable_req changes mid-frame are ignored until the next FRAME_START.
- Latency:
  - kern_dv is exactly 1 cycle after the dvi cycle that caused it.
  - rowbuf_we is combinational from dvi/dtypei/state/col_addr, zero latency.
- Simultaneous events: a FRAME_START arriving in ROW aborts the row with no error; the FRAME_START actions apply.
- KERNEL_SIZE=2 (single buffer): wr_sel stays 0.

Test Plan:
- enable_req=1; FRAME_START, then 4 rows of 6 pixels each wrapped in ROW_START/ROW_END; KERNEL_SIZE=3 -> kern_dv is 0 for rows 0-1; rows 2-3 give 4 pixel strobes each (cols 2..5); wr_sel sequence over ROW_ENDs is 0,1,0,1.
- One row of MAX_COLS+3 pixels -> 1288 writes with col_addr ending at 1288; overflow_err=1 from the 1289th pixel; next FRAME_START clears it.
- Toggle enable_req 1->0 mid-frame -> enable_active stays 1 until the next FRAME_START, then 0; afterwards rowbuf_we never asserts and every dvi cycle gives kern_dv=1 one cycle later.
- Pixel before any ROW_START, and a ROW_END while in FRAME -> protocol_err=1, no writes, col_addr unchanged.
- Assert resetb low mid-row (col_addr=100, wr_sel=1) -> all outputs go to 0 asynchronously; the next frame behaves identically to the first-frame scenario.
- dvi deasserted for 5 cycles between pixels -> col_addr and state hold, kern_dv=0 during the gap, no missed or duplicate writes.
